// File: rtl/mdu_div_ctrl.sv
// Divide-unit front end: sequences one DIV/DIVU/REM/REMU op through an
// external iterative divider, resolving divide-by-zero and overflow locally.
module mdu_div_ctrl #(
    parameter bit BYPASS_SPECIAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    output logic        div_in_valid,
    input  logic        div_in_ready,
    output logic        div_in_sign,
    output logic [31:0] div_in_a,
    output logic [31:0] div_in_b,
    input  logic        div_out_valid,
    output logic        div_out_ready,
    input  logic [31:0] div_out_quot,
    input  logic [31:0] div_out_rem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        rem_q;
    logic        sign_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;

    logic        in_accept;
    logic        in_signed;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] spec_data;

    assign in_accept = in_valid & in_ready;
    assign in_signed = ~in_op[0];
    assign div_zero  = (in_rs2 == 32'h0);
    assign overflow  = in_signed
                     & (in_rs1 == 32'h8000_0000)
                     & (in_rs2 == 32'hFFFF_FFFF);
    assign special   = BYPASS_SPECIAL & (div_zero | overflow);

    // Divide-by-zero and overflow are mutually exclusive (rs2 differs).
    always_comb begin
        spec_data = 32'h0;
        if (in_op[1]) begin
            spec_data = div_zero ? in_rs1 : 32'h0;
        end else begin
            spec_data = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_accept) begin
                    state_d = special ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (div_in_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_out_valid) state_d = S_DONE;
            end
            S_DONE: begin
                if (in_accept) begin
                    state_d = special ? S_DONE : S_ISSUE;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        in_ready      = 1'b0;
        div_in_valid  = 1'b0;
        div_out_ready = 1'b0;
        out_valid     = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready      = 1'b1;
            S_ISSUE: div_in_valid  = 1'b1;
            S_WAIT:  div_out_ready = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= 1'b0;
            sign_q <= 1'b0;
            a_q    <= 32'h0;
            b_q    <= 32'h0;
            rd_q   <= 5'h0;
            data_q <= 32'h0;
        end else if (in_accept && !flush) begin
            rem_q  <= in_op[1];
            sign_q <= in_signed;
            a_q    <= in_rs1;
            b_q    <= in_rs2;
            rd_q   <= in_rd;
            if (special) data_q <= spec_data;
        end else if (state_q == S_WAIT && div_out_valid && !flush) begin
            data_q <= rem_q ? div_out_rem : div_out_quot;
        end
    end

    assign div_in_sign = sign_q;
    assign div_in_a    = a_q;
    assign div_in_b    = b_q;
    assign out_rd      = rd_q;
    assign out_data    = data_q;

endmodule

// File: doc/mdu_div_ctrl.md
MDU_DIV_CTRL -- requirements
Module: mdu_div_ctrl

Interface
REQ-001 The block SHALL have parameter BYPASS_SPECIAL, default 1, meaning that divide-by-zero and signed overflow are resolved locally without using the divider.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit: discards the in-flight op; the same signal drives the divider's flush.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_op (input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU), in_rs1 (input, 32), in_rs2 (input, 32), in_rd (input, 5).
REQ-006 The block SHALL have ports div_in_valid (output, 1), div_in_ready (input, 1), div_in_sign (output, 1), div_in_a (output, 32), div_in_b (output, 32).
REQ-007 The block SHALL have ports div_out_valid (input, 1), div_out_ready (output, 1), div_out_quot (input, 32), div_out_rem (input, 32).
REQ-008 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_rd (output, 5), out_data (output, 32).

Function
REQ-009 The block SHALL implement four states: IDLE, ISSUE, WAIT and DONE.
REQ-010 Handshakes SHALL complete on valid & ready in the same cycle, and a valid SHALL NOT depend combinationally on the matching ready.
REQ-011 in_ready SHALL be 1 in IDLE and in DONE when out_ready=1, and 0 otherwise.
REQ-012 On an input accept, the block SHALL register op, rs1, rs2 and rd.
REQ-013 On an input accept, signed = ~in_op[0].
REQ-014 On an input accept, the op SHALL be special if BYPASS_SPECIAL=1 and either rs2==0, or signed and rs1==0x80000000 and rs2==0xFFFFFFFF.
REQ-015 A special op SHALL go to DONE with the result computed locally.
REQ-016 A non-special op SHALL go to ISSUE.
REQ-017 Special results: divide-by-zero gives quot=0xFFFFFFFF and rem=rs1; overflow gives quot=0x80000000 and rem=0.
REQ-018 In ISSUE, div_in_valid=1 with div_in_sign=signed, div_in_a=rs1 and div_in_b=rs2 held stable; a divider accept SHALL move the block to WAIT.
REQ-019 In WAIT, div_out_ready=1; on div_out_valid, the block SHALL capture div_out_quot (op[1]=0) or div_out_rem (op[1]=1) into out_data and go to DONE.
REQ-020 In DONE, out_valid=1 with out_data and out_rd stable until out_ready=1.
REQ-021 In DONE with out_ready=1, the block SHALL go to IDLE, or take a new op directly if in_valid=1 (back-to-back).
REQ-022 Latency from input accept to out_valid SHALL be 3 cycles for a divider op that sees no stall and 1 cycle for a special op.
REQ-023 flush=1 SHALL force IDLE at the next edge from any state.
REQ-024 A flush SHALL drop any pending output.
REQ-025 An input accepted in the same cycle as flush SHALL be discarded.
REQ-026 div_out_valid seen outside WAIT SHALL be ignored.
REQ-027 div_in_valid, div_out_ready and out_valid SHALL be 0 except in ISSUE, WAIT and DONE respectively.
REQ-028 out_data SHALL be a full 32-bit two's-complement value with no truncation or sign rework, since the divider returns signed results.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock edge, force IDLE, in_ready=1, out_valid=0, div_in_valid=0 and div_out_ready=0.
REQ-030 reset=0 SHALL likewise force out_data=0, out_rd=0, div_in_a=0, div_in_b=0 and div_in_sign=0.
REQ-031 A reset asserted mid-operation SHALL abandon the op, with no output produced after deassertion.
REQ-032 Deassertion SHALL take effect at the first clock edge with reset=1.

Verification
REQ-033 DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5, divider ready -> div_in_valid 1 cycle after accept, out_valid 3 cycles after accept, out_data=0xFFFFFFFD, out_rd=5; REM with the same operands -> 0xFFFFFFFF.
REQ-034 DIVU rs1=100, rs2=0 -> out_valid 1 cycle after accept, out_data=0xFFFFFFFF, div_in_valid never 1; REMU with the same operands -> out_data=100.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> out_data=0x80000000; REM with the same operands -> 0; no divider handshake; with BYPASS_SPECIAL=0 the op goes to the divider.
REQ-036 out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_rd stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted in the same cycle.
REQ-037 div_in_ready=0 for 4 cycles in ISSUE -> div_in_a, div_in_b and div_in_sign stable; then flush in WAIT -> IDLE next cycle, no out_valid, and a later div_out_valid pulse is ignored.
REQ-038 reset driven low mid-WAIT between edges -> all outputs take reset values before the next edge; after release, in_ready=1 and no stale result appears.
